trigger_sequencer: RTL
======================

// Module: trigger_sequencer
// PURPOSE
//  Sequences threshold-trigger capture for the ADC comparator datapath. Owns the comparator
//  threshold register, qualifies its per-sample hit flag over a minimum width, then emits a
//  framed capture window of post-trigger samples, followed by a holdoff period.
//  Sits between the comparator outputs (hit/sat/sample) and the downstream capture buffer/DMA.
// PARAMETERS
//  DATA_W   16  sample and threshold width
//  CNT_W    16  width of length registers and window/holdoff/width counters
//  TCNT_W   32  width of trigger event counter
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous, active-low reset (0 = reset)
//  cfg_load      in   1       pulse: latch cfg_* into shadow registers
//  cfg_thrsld    in   DATA_W  threshold value for comparator
//  cfg_min_w     in   CNT_W   consecutive hits required to trigger (0 treated as 1)
//  cfg_post_len  in   CNT_W   samples per capture window (0 treated as 1)
//  cfg_holdoff   in   CNT_W   holdoff clk cycles after window (0 treated as 1)
//  cfg_cont      in   1       1 = re-arm after holdoff, 0 = single shot
//  arm           in   1       pulse: IDLE -> ARMED
//  abort         in   1       pulse: any state -> IDLE
//  s_valid       in   1       comparator sample strobe
//  s_hit         in   1       comparator threshold flag (data_out)
//  s_sat         in   1       comparator saturation flag (comp_out)
//  s_data        in   DATA_W  comparator sample (sig_array)
//  thrsld        out  DATA_W  threshold driven to comparator
//  cap_valid     out  1       capture sample strobe
//  cap_first     out  1       with cap_valid: first sample of window
//  cap_last      out  1       with cap_valid: last sample of window
//  cap_data      out  DATA_W  captured sample
//  trig_pulse    out  1       one-cycle trigger indication
//  busy          out  1       state != IDLE
//  cfg_err       out  1       one-cycle: cfg_load rejected (state != IDLE)
//  trig_cnt      out  TCNT_W  triggers since reset, wraps
//  sat_cnt       out  CNT_W   saturated samples in last/current window, saturating
// BEHAVIOUR
//  - Reset: state IDLE; thrsld=16'hFFFF (never hits); all cap_*, trig_pulse, cfg_err=0;
//    trig_cnt=0, sat_cnt=0; shadow lengths=1, cfg_cont=0. All outputs are registered.
//  - cfg_load honoured only in IDLE (takes effect next cycle); otherwise ignored, cfg_err=1 for 1 cycle.
//  - FSM: IDLE -arm-> ARMED -qualified-> CAPTURE -window done-> HOLDOFF -> ARMED (cont) / IDLE.
//  - ARMED: hit_run counter +1 on s_valid&s_hit; cleared on s_valid&~s_hit; unchanged if !s_valid.
//    When hit_run reaches min_w on a valid sample, that sample is first of window -> CAPTURE.
//  - CAPTURE: every s_valid sample forwarded; window counts post_len valid samples incl. first.
//  - Latency: sample at cycle n appears on cap_data/cap_valid at n+1; trig_pulse coincides
//    with cap_first. post_len=1 -> cap_first and cap_last on same beat.
//  - sat_cnt cleared on window's first sample, then +1 per captured sample with s_sat; holds at max.
//  - trig_cnt +1 per trigger, wraps at 2^TCNT_W.
//  - HOLDOFF: ignores samples for max(holdoff,1) cycles; hit_run cleared on ARMED entry.
//  - abort has priority over everything incl. arm in same cycle; abort mid-window: no cap_last,
//    cap_valid deasserts next cycle. arm outside IDLE ignored.
// CONFIGURATION
//  TRIG_TIMESTAMP_EN: defined -> free-running TCNT_W timestamp counter (reset 0, wraps) and
//  output trig_ts[TCNT_W-1:0], latched with value at the qualifying sample's cycle, valid with
//  trig_pulse and held until next trigger. Undefined -> no counter, no trig_ts port.
// STRUCTURE
//  Package trig_seq_pkg: state enum (IDLE/ARMED/CAPTURE/HOLDOFF), DATA_W/CNT_W/TCNT_W defaults,
//  threshold reset constant. One sub-module: trig_len_counter (loadable down-counter with
//  zero-as-one rule), instanced for window and holdoff.
// TESTING
//  1 cfg min_w=3 post_len=4, arm; hits 1,1,0,1,1,1 -> trigger on 6th sample, 4 cap_valid, first/last framed.
//  2 s_valid gaps inside window -> cap_valid only on valid beats, still exactly post_len samples.
//  3 cont=1 holdoff=5 -> 5 idle cycles then re-arm; 2nd trigger, trig_cnt=2; cont=0 -> busy=0.
//  4 abort mid-window (2 of 4 sent) -> no cap_last, IDLE next cycle; abort+arm same cycle -> IDLE.
//  5 cfg_load while ARMED -> cfg_err pulse, thrsld unchanged; in IDLE thrsld=new next cycle.
//  6 rst low mid-CAPTURE -> all outputs at reset values immediately; 5 sat samples -> sat_cnt=5.

Source files
------------

// File: rtl/trig_seq_pkg.sv
// Shared types and defaults for the trigger sequencer.
package trig_seq_pkg;

  localparam int unsigned DATA_W_DFLT = 16;
  localparam int unsigned CNT_W_DFLT  = 16;
  localparam int unsigned TCNT_W_DFLT = 32;

  // Threshold resets to all ones so the comparator never hits before configuration.
  localparam logic THRSLD_RST_BIT = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StCapture,
    StHoldoff
  } state_e;

endpackage

// File: rtl/trig_len_counter.sv
// Loadable down-counter; a programmed length of 0 is treated as 1.
// o_last flags that a decrement in this cycle consumes the final unit, including the
// cycle in which the counter is loaded.
module trig_len_counter
  import trig_seq_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DFLT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_eff_len;
  logic [CNT_W-1:0] w_cur;

  // Effective length and the count seen by this cycle (fresh load bypasses the register).
  always_comb begin
    w_eff_len = (i_len == '0) ? CNT_W'(1) : i_len;
    w_cur     = i_load ? w_eff_len : r_cnt;
    o_last    = (w_cur == CNT_W'(1));
  end

  // Count register: load and/or consume one unit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt <= '0;
    end else if (i_dec && (w_cur != '0)) begin
      r_cnt <= w_cur - CNT_W'(1);
    end else if (i_load) begin
      r_cnt <= w_cur;
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Threshold-trigger capture sequencer: qualifies comparator hits over a minimum width,
// frames a post-trigger capture window, then waits out a holdoff period.
// Optional feature: define TRIG_TIMESTAMP_EN to add a free-running timestamp and o_trig_ts.
module trigger_sequencer
  import trig_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned CNT_W  = CNT_W_DFLT,
  parameter int unsigned TCNT_W = TCNT_W_DFLT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_load,
  input  logic [DATA_W-1:0] i_cfg_thrsld,
  input  logic [CNT_W-1:0]  i_cfg_min_w,
  input  logic [CNT_W-1:0]  i_cfg_post_len,
  input  logic [CNT_W-1:0]  i_cfg_holdoff,
  input  logic              i_cfg_cont,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic              i_s_valid,
  input  logic              i_s_hit,
  input  logic              i_s_sat,
  input  logic [DATA_W-1:0] i_s_data,
  output logic [DATA_W-1:0] o_thrsld,
  output logic              o_cap_valid,
  output logic              o_cap_first,
  output logic              o_cap_last,
  output logic [DATA_W-1:0] o_cap_data,
  output logic              o_trig_pulse,
  output logic              o_busy,
  output logic              o_cfg_err,
  output logic [TCNT_W-1:0] o_trig_cnt,
`ifdef TRIG_TIMESTAMP_EN
  output logic [TCNT_W-1:0] o_trig_ts,
`endif
  output logic [CNT_W-1:0]  o_sat_cnt
);

  state_e            r_state;
  logic [DATA_W-1:0] r_thrsld;
  logic [CNT_W-1:0]  r_min_w;
  logic [CNT_W-1:0]  r_post_len;
  logic [CNT_W-1:0]  r_holdoff;
  logic              r_cont;
  logic [CNT_W-1:0]  r_hit_run;
  logic              r_cap_valid;
  logic              r_cap_first;
  logic              r_cap_last;
  logic [DATA_W-1:0] r_cap_data;
  logic              r_trig_pulse;
  logic              r_busy;
  logic              r_cfg_err;
  logic [TCNT_W-1:0] r_trig_cnt;
  logic [CNT_W-1:0]  r_sat_cnt;

  logic [CNT_W-1:0]  w_min_m1;
  logic              w_trig;
  logic              w_cap_beat;
  logic              w_win_dec;
  logic              w_win_last;
  logic              w_win_end;
  logic              w_ho_dec;
  logic              w_ho_last;

  // Qualification and window-framing decode for the current cycle.
  always_comb begin
    w_min_m1   = (r_min_w == '0) ? '0 : r_min_w - CNT_W'(1);
    w_trig     = (r_state == StArmed) && i_s_valid && i_s_hit && (r_hit_run == w_min_m1)
                 && !i_abort;
    w_cap_beat = (r_state == StCapture) && i_s_valid && !i_abort;
    w_win_dec  = w_trig || w_cap_beat;
    w_win_end  = w_win_dec && w_win_last;
    w_ho_dec   = (r_state == StHoldoff) && !i_abort;
  end

  trig_len_counter #(
    .CNT_W (CNT_W)
  ) u_win_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_trig),
    .i_len  (r_post_len),
    .i_dec  (w_win_dec),
    .o_last (w_win_last)
  );

  trig_len_counter #(
    .CNT_W (CNT_W)
  ) u_holdoff_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_win_end),
    .i_len  (r_holdoff),
    .i_dec  (w_ho_dec),
    .o_last (w_ho_last)
  );

  // Sequencer FSM, configuration shadow registers and all registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_thrsld     <= {DATA_W{THRSLD_RST_BIT}};
      r_min_w      <= CNT_W'(1);
      r_post_len   <= CNT_W'(1);
      r_holdoff    <= CNT_W'(1);
      r_cont       <= 1'b0;
      r_hit_run    <= '0;
      r_cap_valid  <= 1'b0;
      r_cap_first  <= 1'b0;
      r_cap_last   <= 1'b0;
      r_cap_data   <= '0;
      r_trig_pulse <= 1'b0;
      r_busy       <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_trig_cnt   <= '0;
      r_sat_cnt    <= '0;
    end else begin
      r_cap_valid  <= 1'b0;
      r_cap_first  <= 1'b0;
      r_cap_last   <= 1'b0;
      r_trig_pulse <= 1'b0;
      r_cfg_err    <= 1'b0;

      if (i_cfg_load) begin
        if (r_state == StIdle) begin
          r_thrsld   <= i_cfg_thrsld;
          r_min_w    <= i_cfg_min_w;
          r_post_len <= i_cfg_post_len;
          r_holdoff  <= i_cfg_holdoff;
          r_cont     <= i_cfg_cont;
        end else begin
          r_cfg_err <= 1'b1;
        end
      end

      if (i_abort) begin
        r_state <= StIdle;
        r_busy  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_arm) begin
              r_state   <= StArmed;
              r_busy    <= 1'b1;
              r_hit_run <= '0;
            end
          end
          StArmed: begin
            if (w_trig) begin
              r_cap_valid  <= 1'b1;
              r_cap_first  <= 1'b1;
              r_cap_last   <= w_win_end;
              r_cap_data   <= i_s_data;
              r_trig_pulse <= 1'b1;
              r_trig_cnt   <= r_trig_cnt + TCNT_W'(1);
              r_sat_cnt    <= CNT_W'(i_s_sat);
              r_hit_run    <= '0;
              r_state      <= w_win_end ? StHoldoff : StCapture;
            end else if (i_s_valid) begin
              r_hit_run <= i_s_hit ? r_hit_run + CNT_W'(1) : '0;
            end
          end
          StCapture: begin
            if (w_cap_beat) begin
              r_cap_valid <= 1'b1;
              r_cap_last  <= w_win_end;
              r_cap_data  <= i_s_data;
              if (i_s_sat && (r_sat_cnt != '1)) begin
                r_sat_cnt <= r_sat_cnt + CNT_W'(1);
              end
              if (w_win_end) begin
                r_state <= StHoldoff;
              end
            end
          end
          StHoldoff: begin
            if (w_ho_last) begin
              if (r_cont) begin
                r_state   <= StArmed;
                r_hit_run <= '0;
              end else begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
              end
            end
          end
          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [TCNT_W-1:0] r_ts;
  logic [TCNT_W-1:0] r_trig_ts;

  // Free-running timestamp; captured on the qualifying sample's cycle.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_ts      <= '0;
      r_trig_ts <= '0;
    end else begin
      r_ts <= r_ts + TCNT_W'(1);
      if (w_trig) begin
        r_trig_ts <= r_ts;
      end
    end
  end

  assign o_trig_ts = r_trig_ts;
`else
  // Timestamp hardware is not built in this configuration.
`endif

  assign o_thrsld     = r_thrsld;
  assign o_cap_valid  = r_cap_valid;
  assign o_cap_first  = r_cap_first;
  assign o_cap_last   = r_cap_last;
  assign o_cap_data   = r_cap_data;
  assign o_trig_pulse = r_trig_pulse;
  assign o_busy       = r_busy;
  assign o_cfg_err    = r_cfg_err;
  assign o_trig_cnt   = r_trig_cnt;
  assign o_sat_cnt    = r_sat_cnt;

endmodule
